data_bus_responder: RTL and testbench
=====================================

DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024, meaning the number of 32-bit RAM words (power of two).
REQ-002 SHALL have parameter TICK_DIV, default 1, meaning clk cycles per mtime increment (>=1).
REQ-003 SHALL have parameter TIMER_BASE, default 32'hFFFF_FF00, meaning the base address of the timer register block.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 memAddr  input  32  byte address from the CPU.
REQ-007 memWr  input  1  write strobe for the current cycle.
REQ-008 wrMask  input  4  byte-lane enables; bit i enables bits [8i+7:8i].
REQ-009 memWriteData  input  32  lane-aligned write data.
REQ-010 memReadData  output  32  read data for the word containing memAddr.
REQ-011 timerIrq  output  1  machine timer interrupt request, level.
REQ-012 busErr  output  1  sticky unmapped-access flag.

Function
REQ-013 Address decode SHALL be: RAM when memAddr < RAM_WORDS*4; timer when memAddr[31:4] == TIMER_BASE[31:4]; otherwise unmapped.
REQ-014 Address bits [1:0] SHALL be ignored for word selection; lane selection is carried only by wrMask.
REQ-015 The read path SHALL be combinational, with zero-cycle latency from memAddr to memReadData, so that a single-cycle CPU completes loads in the same cycle.
REQ-016 A RAM write SHALL update only the enabled lanes at the rising edge where memWr=1; a read of the same word in that cycle returns the pre-write value.
REQ-017 A write with wrMask=0 SHALL leave state unchanged.
REQ-018 Timer registers: +0 mtime[31:0], +4 mtime[63:32], +8 mtimecmp[31:0], +C mtimecmp[63:32]; byte-lane writes SHALL be honoured.
REQ-019 The prescaler counter SHALL count 0..TICK_DIV-1; mtime SHALL increment by 1 in the cycle the counter wraps to 0.
REQ-020 mtime SHALL wrap from 2^64-1 to 0 without side effects.
REQ-021 A CPU write to an mtime word SHALL take priority over the increment in the same cycle; the other word SHALL still receive the carry of the increment.
REQ-022 timerIrq SHALL be registered: timerIrq = (mtime >= mtimecmp), unsigned 64-bit, evaluated one cycle after any mtime or mtimecmp change.
REQ-023 An unmapped read SHALL return 0; an unmapped write SHALL be ignored; either SHALL set busErr at the next edge.
REQ-024 busErr SHALL clear only on reset.

Reset
REQ-025 On reset, mtime=0, the prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, timerIrq=0 and busErr=0.
REQ-026 RAM contents SHALL NOT be affected by reset; reset asserted mid-write SHALL suppress that write to timer registers only.

Configuration
REQ-027 Macro DBUS_TIMER_EN: when defined, the timer block (REQ-018..022) SHALL be present.
REQ-028 Without DBUS_TIMER_EN, the timer addresses SHALL decode as unmapped and timerIrq SHALL be tied to 0.

Structure
REQ-029 TIMER_BASE default, the timer register offsets and the lane-merge width SHALL live in the shared constants header alongside XLEN.
REQ-030 The RAM array with byte-lane write SHALL be a sub-module named byteRam32; decode, timer and error logic SHALL stay in the top module.

Verification
REQ-031 Write 32'hAABBCCDD to 0x10 with wrMask=4'b1111, then write 32'h0000_1100 with wrMask=4'b0010 -> a read of 0x10 returns 32'hAABB11DD.
REQ-032 Write 32'h0000_0005 to TIMER_BASE+8 and 0 to TIMER_BASE+C with TICK_DIV=1 -> timerIrq rises exactly one cycle after mtime reaches 5.
REQ-033 Write 32'hFFFF_FFFF to +0 and +4 -> after one tick, mtime reads 0 on both words and timerIrq is unaffected by the wrap (mtimecmp = all-ones).
REQ-034 Write to +0 in a cycle where a tick occurs -> mtime[31:0] equals the written value next cycle, not the value plus 1.
REQ-035 Read 0x8000_0000 -> memReadData=0 and busErr=1 next cycle, remaining 1 until reset; reset -> busErr=0 and RAM data intact.
REQ-036 Build without DBUS_TIMER_EN, access TIMER_BASE -> read returns 0, busErr=1 and timerIrq remains 0.

Source files
------------

// File: rtl/data_bus_responder_pkg.sv
// Shared constants for the data bus responder: word width, lane geometry,
// timer block placement and register offsets, plus the byte-lane merge helper.
package data_bus_responder_pkg;

   localparam int XLEN   = 32;
   localparam int LANE_W = 8;
   localparam int LANES  = XLEN / LANE_W;

   localparam logic [31:0] TIMER_BASE_DEFAULT = 32'hFFFF_FF00;

   localparam logic [3:0] OFS_MTIME_LO    = 4'h0;
   localparam logic [3:0] OFS_MTIME_HI    = 4'h4;
   localparam logic [3:0] OFS_MTIMECMP_LO = 4'h8;
   localparam logic [3:0] OFS_MTIMECMP_HI = 4'hC;

   typedef enum logic [1:0] {
      TREG_MTIME_LO    = OFS_MTIME_LO[3:2],
      TREG_MTIME_HI    = OFS_MTIME_HI[3:2],
      TREG_MTIMECMP_LO = OFS_MTIMECMP_LO[3:2],
      TREG_MTIMECMP_HI = OFS_MTIMECMP_HI[3:2]
   } treg_e;

   typedef enum logic [1:0] {
      REGION_RAM   = 2'd0,
      REGION_TIMER = 2'd1,
      REGION_NONE  = 2'd2
   } region_e;

   // Replace only the lanes whose mask bit is set; mask 0 returns old_word unchanged.
   function automatic logic [XLEN-1:0] lane_merge(
      input logic [XLEN-1:0]  old_word,
      input logic [XLEN-1:0]  new_word,
      input logic [LANES-1:0] mask
   );
      logic [XLEN-1:0] merged;
      merged = old_word;
      for (int i = 0; i < LANES; i++) begin
         if (mask[i]) begin
            merged[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/data_bus_responder_byteRam32.sv
// Word-addressed 32-bit RAM with per-byte write enables and asynchronous read,
// so the CPU sees load data in the same cycle; contents are never reset.
module byteRam32
   import data_bus_responder_pkg::*;
#(
   parameter int WORDS = 1024
) (
   input  logic                      clk,
   input  logic [$clog2(WORDS)-1:0]  addr,
   input  logic                      we,
   input  logic [LANES-1:0]          wr_mask,
   input  logic [XLEN-1:0]           wr_data,
   output logic [XLEN-1:0]           rd_data
);

   logic [XLEN-1:0] mem [WORDS];

   // Read returns the stored word, so a same-cycle write is seen only after the edge.
   assign rd_data = mem[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= lane_merge(mem[addr], wr_data, wr_mask);
      end
   end

endmodule

// File: rtl/data_bus_responder.sv
// Single-cycle CPU data bus responder: RAM, optional machine timer (build with
// DBUS_TIMER_EN), and a sticky bus-error flag for unmapped accesses.
module data_bus_responder
   import data_bus_responder_pkg::*;
#(
   parameter int          RAM_WORDS  = 1024,
   parameter int          TICK_DIV   = 1,
   parameter logic [31:0] TIMER_BASE = TIMER_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] memAddr,
   input  logic        memWr,
   input  logic [3:0]  wrMask,
   input  logic [31:0] memWriteData,
   output logic [31:0] memReadData,
   output logic        timerIrq,
   output logic        busErr
);

   localparam int          AW        = $clog2(RAM_WORDS);
   localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

   region_e     region;
   logic        timer_hit;
   logic [31:0] ram_rdata;
   logic [31:0] timer_rdata;
   logic        bus_err_q;
   logic        bus_err_d;

   // RAM wins if it ever overlaps the timer window.
   always_comb begin
      region = REGION_NONE;
      if ({1'b0, memAddr} < RAM_BYTES) begin
         region = REGION_RAM;
      end else if (timer_hit) begin
         region = REGION_TIMER;
      end
   end

   byteRam32 #(
      .WORDS (RAM_WORDS)
   ) u_ram (
      .clk     (clk),
      .addr    (memAddr[AW+1:2]),
      .we      (memWr && (region == REGION_RAM)),
      .wr_mask (wrMask),
      .wr_data (memWriteData),
      .rd_data (ram_rdata)
   );

`ifdef DBUS_TIMER_EN
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0] presc_q,    presc_d;
   logic [63:0]   mtime_q,    mtime_d;
   logic [63:0]   mtimecmp_q, mtimecmp_d;
   logic          irq_q,      irq_d;
   logic          tick;
   logic [63:0]   mtime_inc;
   logic          timer_wr;

   assign timer_hit = (memAddr[31:4] == TIMER_BASE[31:4]);
   assign timer_wr  = memWr && (region == REGION_TIMER);

   always_comb begin
      tick       = (presc_q == PW'(TICK_DIV - 1));
      presc_d    = tick ? '0 : presc_q + PW'(1);
      mtime_inc  = mtime_q + {63'd0, tick};
      mtime_d    = mtime_inc;
      mtimecmp_d = mtimecmp_q;
      // A CPU write overrides the incremented word; the other word keeps the carry.
      if (timer_wr) begin
         unique case (treg_e'(memAddr[3:2]))
            TREG_MTIME_LO:    mtime_d[31:0]     = lane_merge(mtime_inc[31:0], memWriteData, wrMask);
            TREG_MTIME_HI:    mtime_d[63:32]    = lane_merge(mtime_inc[63:32], memWriteData, wrMask);
            TREG_MTIMECMP_LO: mtimecmp_d[31:0]  = lane_merge(mtimecmp_q[31:0], memWriteData, wrMask);
            TREG_MTIMECMP_HI: mtimecmp_d[63:32] = lane_merge(mtimecmp_q[63:32], memWriteData, wrMask);
            default:          mtime_d           = mtime_inc;
         endcase
      end
      irq_d = (mtime_q >= mtimecmp_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q    <= '0;
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         irq_q      <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         irq_q      <= irq_d;
      end
   end

   always_comb begin
      timer_rdata = '0;
      unique case (treg_e'(memAddr[3:2]))
         TREG_MTIME_LO:    timer_rdata = mtime_q[31:0];
         TREG_MTIME_HI:    timer_rdata = mtime_q[63:32];
         TREG_MTIMECMP_LO: timer_rdata = mtimecmp_q[31:0];
         TREG_MTIMECMP_HI: timer_rdata = mtimecmp_q[63:32];
         default:          timer_rdata = '0;
      endcase
   end

   assign timerIrq = irq_q;
`else
   logic unused_timer_cfg;

   assign unused_timer_cfg = ^{TIMER_BASE, 32'(TICK_DIV)};
   assign timer_hit        = 1'b0;
   assign timer_rdata      = '0;
   assign timerIrq         = 1'b0;
`endif

   always_comb begin
      memReadData = '0;
      unique case (region)
         REGION_RAM:   memReadData = ram_rdata;
         REGION_TIMER: memReadData = timer_rdata;
         default:      memReadData = '0;
      endcase
   end

   assign bus_err_d = bus_err_q || (region == REGION_NONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         bus_err_q <= 1'b0;
      end else begin
         bus_err_q <= bus_err_d;
      end
   end

   assign busErr = bus_err_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench for data_bus_responder: a driver pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares them.
module tb_data_bus_responder;

   localparam int          RAM_WORDS  = 64;
   localparam int          TICK_DIV   = 1;
   localparam logic [31:0] TIMER_BASE = 32'hFFFF_FF00;
`ifdef DBUS_TIMER_EN
   localparam bit TIMER_EN = 1'b1;
`else
   localparam bit TIMER_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] memAddr;
   logic        memWr;
   logic [3:0]  wrMask;
   logic [31:0] memWriteData;
   logic [31:0] memReadData;
   logic        timerIrq;
   logic        busErr;

   always #5 clk = ~clk;

   data_bus_responder #(
      .RAM_WORDS  (RAM_WORDS),
      .TICK_DIV   (TICK_DIV),
      .TIMER_BASE (TIMER_BASE)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .memAddr      (memAddr),
      .memWr        (memWr),
      .wrMask       (wrMask),
      .memWriteData (memWriteData),
      .memReadData  (memReadData),
      .timerIrq     (timerIrq),
      .busErr       (busErr)
   );

   typedef struct {
      int          id;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] rdata;
      bit          chk_rdata;
      bit          bus_err;
      bit          irq;
      bit          chk_flags;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_txn    = 0;

   // Reference model state: plain arrays and 64-bit integers.
   logic [31:0] m_ram   [RAM_WORDS];
   bit          m_known [RAM_WORDS];
   logic [63:0] m_mtime;
   logic [63:0] m_cmp;
   bit          m_irq;
   bit          m_err;
   bit          m_valid = 1'b0;
   int          m_presc;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] m);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
      end
      return r;
   endfunction

   function automatic void check(input string name, input int id, input logic [31:0] addr,
                                 input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s txn=%0d addr=%08h got=%08h expected=%08h", name, id, addr, act, req);
      end
   endfunction

   // Drive one bus cycle; called 1 time unit after a rising edge.
   task automatic step(input logic [31:0] a, input logic w, input logic [3:0] m,
                       input logic [31:0] d, input logic r);
      exp_t        e;
      int          kind;
      int          widx;
      logic [63:0] nt;
      bit          tick;
      memAddr      = a;
      memWr        = w;
      wrMask       = m;
      memWriteData = d;
      reset        = r;
      if ({32'd0, a} < 64'(RAM_WORDS) * 64'd4) kind = 0;
      else if (TIMER_EN && (a[31:4] == TIMER_BASE[31:4])) kind = 1;
      else kind = 2;
      widx        = int'(a >> 2);
      e.id        = n_txn++;
      e.addr      = a;
      e.wr        = w;
      e.rdata     = 32'd0;
      e.chk_rdata = 1'b1;
      e.bus_err   = m_err;
      e.irq       = m_irq;
      e.chk_flags = m_valid;
      if (kind == 0) begin
         e.chk_rdata = m_known[widx];
         e.rdata     = m_ram[widx];
      end else if (kind == 1) begin
         e.chk_rdata = m_valid;
         case (a[3:2])
            2'd0:    e.rdata = m_mtime[31:0];
            2'd1:    e.rdata = m_mtime[63:32];
            2'd2:    e.rdata = m_cmp[31:0];
            default: e.rdata = m_cmp[63:32];
         endcase
      end
      exp_q.push_back(e);
      // RAM ignores reset entirely.
      if (kind == 0 && w) begin
         m_ram[widx] = merge_bytes(m_ram[widx], d, m);
         if (m == 4'hF) m_known[widx] = 1'b1;
      end
      if (r) begin
         m_mtime = 64'd0;
         m_cmp   = '1;
         m_irq   = 1'b0;
         m_err   = 1'b0;
         m_presc = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         m_irq = TIMER_EN && (m_mtime >= m_cmp);
         if (kind == 2) m_err = 1'b1;
         if (TIMER_EN) begin
            tick    = (m_presc == TICK_DIV - 1);
            m_presc = tick ? 0 : m_presc + 1;
            nt      = m_mtime + 64'(tick);
            if (w && kind == 1) begin
               case (a[3:2])
                  2'd0:    nt[31:0]     = merge_bytes(nt[31:0], d, m);
                  2'd1:    nt[63:32]    = merge_bytes(nt[63:32], d, m);
                  2'd2:    m_cmp[31:0]  = merge_bytes(m_cmp[31:0], d, m);
                  default: m_cmp[63:32] = merge_bytes(m_cmp[63:32], d, m);
               endcase
            end
            m_mtime = nt;
         end
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         $display("txn %0d addr=%08h wr=%0b rdata=%08h busErr=%0b timerIrq=%0b",
                  e.id, e.addr, e.wr, memReadData, busErr, timerIrq);
         if (e.chk_rdata) check("rdata", e.id, e.addr, memReadData, e.rdata);
         if (e.chk_flags) begin
            check("busErr", e.id, e.addr, 32'(busErr), 32'(e.bus_err));
            check("timerIrq", e.id, e.addr, 32'(timerIrq), 32'(e.irq));
         end
      end
   end

   initial begin
      logic [31:0] a;
      int          sel;
      for (int i = 0; i < RAM_WORDS; i++) m_known[i] = 1'b0;
      memAddr = '0; memWr = 1'b0; wrMask = '0; memWriteData = '0; reset = 1'b1;
      @(posedge clk);
      #1;
      step(32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
      step(32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
      step(32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
      for (int i = 0; i < RAM_WORDS; i++) step(32'(i * 4), 1'b1, 4'hF, $urandom, 1'b0);

      // Lane merge: full write then a single-lane update, then readback.
      step(32'h10, 1'b1, 4'hF, 32'hAABBCCDD, 1'b0);
      step(32'h10, 1'b1, 4'b0010, 32'h0000_1100, 1'b0);
      step(32'h13, 1'b0, 4'h0, 32'h0, 1'b0);
      step(32'h10, 1'b1, 4'h0, 32'h1234_5678, 1'b0);
      step(32'h10, 1'b0, 4'h0, 32'h0, 1'b0);

      if (TIMER_EN) begin
         // Reset during a timer write suppresses it.
         step(TIMER_BASE + 32'h8, 1'b1, 4'hF, 32'h5, 1'b1);
         step(TIMER_BASE + 32'h8, 1'b1, 4'hF, 32'h5, 1'b0);
         step(TIMER_BASE + 32'hC, 1'b1, 4'hF, 32'h0, 1'b0);
         for (int i = 0; i < 8; i++) step(TIMER_BASE, 1'b0, 4'h0, 32'h0, 1'b0);
         step(TIMER_BASE, 1'b0, 4'h0, 32'h0, 1'b1);
         step(TIMER_BASE + 32'h4, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0);
         step(TIMER_BASE + 32'h0, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0);
         step(TIMER_BASE + 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
         step(TIMER_BASE + 32'h4, 1'b0, 4'h0, 32'h0, 1'b0);
         step(TIMER_BASE + 32'h0, 1'b1, 4'hF, 32'h0000_0100, 1'b0);
         step(TIMER_BASE + 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
         step(TIMER_BASE + 32'h0, 1'b1, 4'b0100, 32'h00AB_0000, 1'b0);
         step(TIMER_BASE + 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
      end else begin
         step(TIMER_BASE, 1'b1, 4'hF, 32'h5, 1'b0);
         step(TIMER_BASE + 32'h8, 1'b0, 4'h0, 32'h0, 1'b0);
         step(32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
         step(32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
      end

      // Unmapped read: sticky error until reset, RAM survives reset.
      step(32'h8000_0000, 1'b0, 4'h0, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) step(32'h10, 1'b0, 4'h0, 32'h0, 1'b0);
      step(32'h8000_0000, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1);
      step(32'h10, 1'b0, 4'h0, 32'h0, 1'b0);
      step(32'h20, 1'b0, 4'h0, 32'h0, 1'b0);

      for (int i = 0; i < 400; i++) begin
         sel = int'($urandom_range(0, 15));
         if (sel < 10)      a = $urandom_range(0, RAM_WORDS * 4 - 1);
         else if (sel < 15) a = TIMER_BASE + 32'($urandom_range(0, 15));
         else               a = 32'h4000_0000 + 32'($urandom_range(0, 32'hFFFF));
         step(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
              ($urandom_range(0, 31) == 0));
      end
      step(32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending=%0d expected=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
